// File: rtl/chip8_pkg.sv
// Shared constants and boot-state encoding for the CHIP-8 memory responder.
package chip8_pkg;
  localparam int ADDR_W     = 12;
  localparam int MEM_BYTES  = 4096;
  localparam int FONT_BYTES = 80;

  localparam logic [ADDR_W-1:0] FONT_BASE = 12'h050;
  localparam logic [ADDR_W-1:0] PROG_BASE = 12'h200;
  localparam logic [ADDR_W-1:0] ADDR_MAX  = 12'hFFF;

  typedef enum logic [1:0] {FONT, LOAD, RUN} boot_state_t;
endpackage

// File: rtl/chip8_font_rom.sv
// Standard 0-F hex font, 5 bytes per glyph, indexed by byte.
module chip8_font_rom
  import chip8_pkg::*;
(
  input  logic [6:0] index,
  output logic [7:0] data
);
  localparam logic [0:FONT_BYTES-1][7:0] GLYPHS = {
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  // 0
    8'h20, 8'h60, 8'h20, 8'h20, 8'h70,  // 1
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  // 2
    8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,  // 3
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  // 4
    8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,  // 5
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  // 6
    8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,  // 7
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  // 8
    8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,  // 9
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  // A
    8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,  // B
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  // C
    8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,  // D
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  // E
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80   // F
  };

  assign data = (index < 7'(FONT_BYTES)) ? GLYPHS[index] : 8'h00;
endmodule

// File: rtl/chip8_memory.sv
// 4 KB byte RAM for the CHIP-8 core with a boot sequencer: font copy,
// streamed program load, then hand-over of the array to the core.
module chip8_memory
  import chip8_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] bus_address,
  input  logic [7:0]        bus_wdata,
  input  logic              bus_write,
  output logic [7:0]        bus_rdata,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              cpu_reset_n,
  output logic [ADDR_W-1:0] prog_length
);
  boot_state_t       state;
  logic [6:0]        font_idx;
  logic [7:0]        font_byte;
  logic [7:0]        mem [MEM_BYTES];
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;
  logic [ADDR_W-1:0] load_addr;
  logic              accept;

  chip8_font_rom u_font_rom (
    .index (font_idx),
    .data  (font_byte)
  );

  // Outputs decode straight from state so load_ready never depends on load_valid.
  assign load_ready  = (state == LOAD);
  assign cpu_reset_n = (state == RUN);
  assign accept      = load_ready & load_valid;
  assign load_addr   = PROG_BASE + prog_length;

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    case (state)
      FONT: begin
        we    = 1'b1;
        waddr = FONT_BASE + ADDR_W'(font_idx);
        wdata = font_byte;
      end
      LOAD: begin
        we    = accept;
        waddr = load_addr;
        wdata = load_data;
      end
      RUN: begin
        we    = bus_write;
        waddr = bus_address;
        wdata = bus_wdata;
      end
      default: ;
    endcase
  end

  // Array is deliberately left out of reset: program bytes survive a reboot.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign bus_rdata = mem[bus_address];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= FONT;
      font_idx    <= '0;
      prog_length <= '0;
    end else begin
      case (state)
        FONT: begin
          if (font_idx == 7'(FONT_BYTES - 1)) state <= LOAD;
          else                                font_idx <= font_idx + 7'd1;
        end
        LOAD: begin
          if (accept) begin
            prog_length <= prog_length + 12'd1;
            // Last byte of the array ends the load; the pointer never wraps.
            if (load_last || load_addr == ADDR_MAX) state <= RUN;
          end
        end
        RUN: ;
        default: state <= FONT;
      endcase
    end
  end
endmodule

// File: tb/tb_chip8_memory.sv
// Randomized self-checking bench for chip8_memory against a byte-array model.
module tb_chip8_memory;
  logic        clock;
  logic        reset;
  logic [11:0] bus_address;
  logic [7:0]  bus_wdata;
  logic        bus_write;
  logic [7:0]  bus_rdata;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;
  logic        load_ready;
  logic        cpu_reset_n;
  logic [11:0] prog_length;

  chip8_memory dut (
    .clock       (clock),
    .reset       (reset),
    .bus_address (bus_address),
    .bus_wdata   (bus_wdata),
    .bus_write   (bus_write),
    .bus_rdata   (bus_rdata),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .cpu_reset_n (cpu_reset_n),
    .prog_length (prog_length)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: byte array, which bytes are defined, program length, run flag.
  logic [7:0] ref_mem   [4096];
  bit         ref_known [4096];
  int         ref_len;
  bit         ref_run;
  int         n_cmp, n_bad;

  logic [7:0] font_tbl [80] = '{
    8'hF0,8'h90,8'h90,8'h90,8'hF0, 8'h20,8'h60,8'h20,8'h20,8'h70,
    8'hF0,8'h10,8'hF0,8'h80,8'hF0, 8'hF0,8'h10,8'hF0,8'h10,8'hF0,
    8'h90,8'h90,8'hF0,8'h10,8'h10, 8'hF0,8'h80,8'hF0,8'h10,8'hF0,
    8'hF0,8'h80,8'hF0,8'h90,8'hF0, 8'hF0,8'h10,8'h20,8'h40,8'h40,
    8'hF0,8'h90,8'hF0,8'h90,8'hF0, 8'hF0,8'h90,8'hF0,8'h10,8'hF0,
    8'hF0,8'h90,8'hF0,8'h90,8'h90, 8'hE0,8'h90,8'hE0,8'h90,8'hE0,
    8'hF0,8'h80,8'h80,8'h80,8'hF0, 8'hE0,8'h90,8'h90,8'h90,8'hE0,
    8'hF0,8'h80,8'hF0,8'h80,8'hF0, 8'hF0,8'h80,8'hF0,8'h80,8'h80
  };

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_write(input int a, input logic [7:0] d);
    ref_mem[a]   = d;
    ref_known[a] = 1'b1;
  endtask

  // Offers one byte until accepted (bounded), then updates the model.
  task automatic send_byte(input logic [7:0] d, input logic last);
    bit acc;
    int a;
    acc = 1'b0;
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    for (int c = 0; c < 16; c++) begin
      acc = load_ready;
      tick();
      if (acc) break;
    end
    n_cmp++;
    if (!acc) begin
      n_bad++;
      $display("FAIL send_byte_timeout: load_ready stayed %b, wanted 1", load_ready);
    end else begin
      a = 12'h200 + ref_len;
      model_write(a, d);
      ref_len++;
      if (last || a == 12'hFFF) ref_run = 1'b1;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic core_write(input logic [11:0] a, input logic [7:0] d);
    bus_address = a;
    bus_wdata   = d;
    bus_write   = 1'b1;
    tick();
    bus_write   = 1'b0;
    model_write(int'(a), d);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({load_ready, cpu_reset_n} !== 2'b00 || prog_length !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_state: ready=%b rst_n=%b len=%h, want 0 0 000",
               load_ready, cpu_reset_n, prog_length);
    end
  endtask

  // Releases reset and checks the 80-edge font phase timing.
  task automatic test_font_boot(input string tag);
    reset = 1'b0;
    ref_len = 0;
    ref_run = 1'b0;
    repeat (79) tick();
    n_cmp++;
    if (load_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_ready_edge79: got %b want 0", tag, load_ready);
    end
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 80; i++) model_write(12'h050 + i, font_tbl[i]);
    n_cmp++;
    if (load_ready !== 1'b1 || cpu_reset_n !== 1'b0 || prog_length !== 12'(ref_len)) begin
      n_bad++;
      $display("FAIL %s_edge80: ready=%b rst_n=%b len=%h, want 1 0 %h",
               tag, load_ready, cpu_reset_n, prog_length, 12'(ref_len));
    end
  endtask

  // Reads back every byte the model knows (idle inputs, so nothing changes).
  task automatic test_contents(input string tag);
    for (int a = 0; a < 4096; a++) begin
      if (ref_known[a]) begin
        bus_address = 12'(a);
        #1;
        n_cmp++;
        if (bus_rdata !== ref_mem[a]) begin
          n_bad++;
          $display("FAIL %s_mem[%h]: got %h want %h", tag, a, bus_rdata, ref_mem[a]);
        end
      end
    end
  endtask

  task automatic test_load_gap();
    send_byte(8'h60, 1'b0);
    load_last = 1'b1;  // last without valid must be ignored
    tick();
    load_last = 1'b0;
    n_cmp++;
    if (cpu_reset_n !== 1'b0 || load_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL gap_last_ignored: rst_n=%b ready=%b want 0 1", cpu_reset_n, load_ready);
    end
    send_byte(8'h2A, 1'b1);
    n_cmp++;
    if (cpu_reset_n !== ref_run || load_ready !== !ref_run || prog_length !== 12'(ref_len)) begin
      n_bad++;
      $display("FAIL load_to_run: rst_n=%b ready=%b len=%h want %b %b %h",
               cpu_reset_n, load_ready, prog_length, ref_run, !ref_run, 12'(ref_len));
    end
    test_contents("load_gap");
  endtask

  task automatic test_run();
    logic [11:0] a;
    logic [7:0]  d;
    load_valid = 1'b1;
    load_data  = 8'h99;
    core_write(12'h300, 8'h55);
    bus_address = 12'h300;
    #1;
    n_cmp++;
    if (bus_rdata !== 8'h55) begin
      n_bad++;
      $display("FAIL run_read_300: got %h want 55", bus_rdata);
    end
    // Same-cycle read and write: old data before the edge, new after.
    bus_wdata = 8'hC3;
    bus_write = 1'b1;
    #1;
    n_cmp++;
    if (bus_rdata !== ref_mem[12'h300]) begin
      n_bad++;
      $display("FAIL run_rw_before: got %h want %h", bus_rdata, ref_mem[12'h300]);
    end
    tick();
    bus_write = 1'b0;
    model_write(12'h300, 8'hC3);
    n_cmp++;
    if (bus_rdata !== 8'hC3) begin
      n_bad++;
      $display("FAIL run_rw_after: got %h want c3", bus_rdata);
    end
    core_write(12'h000, 8'hA5);
    for (int i = 0; i < 10; i++) begin
      a = 12'($urandom_range(12'h300, 12'hEFF));
      d = 8'($urandom);
      load_data = 8'($urandom);
      core_write(a, d);
    end
    repeat (3) tick();
    load_valid = 1'b0;
    n_cmp++;
    if (prog_length !== 12'(ref_len) || load_ready !== 1'b0 || cpu_reset_n !== 1'b1) begin
      n_bad++;
      $display("FAIL run_loader_ignored: len=%h ready=%b rst_n=%b want %h 0 1",
               prog_length, load_ready, cpu_reset_n, 12'(ref_len));
    end
    test_contents("run");
  endtask

  task automatic test_reset_midload();
    // Async reset in RUN, loader held valid through the whole font phase.
    load_valid = 1'b1;
    load_data  = 8'h77;
    reset = 1'b1;
    #2;
    n_cmp++;
    if (cpu_reset_n !== 1'b0 || load_ready !== 1'b0 || prog_length !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_in_run: rst_n=%b ready=%b len=%h want 0 0 000",
               cpu_reset_n, load_ready, prog_length);
    end
    tick();
    test_font_boot("valid_in_font");
    test_contents("valid_in_font");
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
    #2;
    reset = 1'b1;
    #2;
    n_cmp++;
    if (cpu_reset_n !== 1'b0 || load_ready !== 1'b0 || prog_length !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_midload: rst_n=%b ready=%b len=%h want 0 0 000",
               cpu_reset_n, load_ready, prog_length);
    end
    tick();
    tick();
    test_font_boot("reboot");
    test_contents("reboot");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3583; i++) send_byte(8'($urandom), 1'b0);
    n_cmp++;
    if (cpu_reset_n !== 1'b0 || prog_length !== 12'(ref_len)) begin
      n_bad++;
      $display("FAIL overflow_pre: rst_n=%b len=%h want 0 %h", cpu_reset_n, prog_length, 12'(ref_len));
    end
    send_byte(8'($urandom), 1'b0);
    n_cmp++;
    if (cpu_reset_n !== ref_run || load_ready !== !ref_run || prog_length !== 12'hE00) begin
      n_bad++;
      $display("FAIL overflow_end: rst_n=%b ready=%b len=%h want %b %b e00",
               cpu_reset_n, load_ready, prog_length, ref_run, !ref_run);
    end
    load_valid = 1'b1;
    load_data  = 8'h3C;
    repeat (3) tick();
    load_valid = 1'b0;
    n_cmp++;
    if (prog_length !== 12'hE00) begin
      n_bad++;
      $display("FAIL overflow_hold: len=%h want e00", prog_length);
    end
    bus_address = 12'h000;
    #1;
    n_cmp++;
    if (bus_rdata !== 8'hA5) begin
      n_bad++;
      $display("FAIL overflow_mem000: got %h want a5", bus_rdata);
    end
    test_contents("overflow");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    ref_len = 0;
    ref_run = 1'b0;
    for (int a = 0; a < 4096; a++) begin
      ref_mem[a]   = 8'h00;
      ref_known[a] = 1'b0;
    end
    reset       = 1'b1;
    bus_address = 12'h000;
    bus_wdata   = 8'h00;
    bus_write   = 1'b0;
    load_valid  = 1'b0;
    load_data   = 8'h00;
    load_last   = 1'b0;
    test_reset();
    test_font_boot("boot");
    test_contents("boot");
    test_load_gap();
    test_run();
    test_reset_midload();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
